// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and encodings for piso_serializer.
// The PARITY encoding exists only when PISO_PARITY_EN is defined.
package piso_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
`ifdef PISO_PARITY_EN
  localparam state_t PARITY = 2'd2;
`endif
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: frame bit counter 0..WIDTH-1 with clear, enable and terminal count.
module piso_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign tc = cnt_q == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with valid/ready input and last marker.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic tc, accept, in_shift, end_bit, shift_bit;

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_shift || tc),
    .en  (in_shift),
    .tc  (tc)
  );

  assign in_shift  = state_q == SHIFT;
  assign shift_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign din_ready = state_q == IDLE || end_bit;
  assign accept    = din_valid && din_ready;
  assign dout_valid = state_q != IDLE;
  assign busy      = state_q != IDLE;
  assign last      = end_bit;

  always_comb sh_d = accept ? din
                   : in_shift ? (MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]})
                   : sh_q;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  // the frame ends on the parity cycle, which also carries the back-to-back handoff
  assign end_bit = state_q == PARITY;
  assign dout    = in_shift ? shift_bit : end_bit & par_q;
  always_comb begin
    par_d   = accept ? ^din : par_q;
    state_d = accept ? SHIFT : end_bit ? IDLE : (in_shift && tc) ? PARITY : state_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_q <= 1'b0;
    else      par_q <= par_d;
`else
  assign end_bit = in_shift && tc;
  assign dout    = in_shift & shift_bit;
  always_comb state_d = accept ? SHIFT : end_bit ? IDLE : state_q;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed vector table plus multi-cycle corner sequences.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq_m;
    logic [7:0] seq_l;
    logic       par;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic rdy_m, dout_m, vld_m, last_m, busy_m;
  logic rdy_l, dout_l, vld_l, last_l, busy_l;
  int n_pass = 0, n_tot = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy_m), .din(din),
    .dout(dout_m), .dout_valid(vld_m), .last(last_m), .busy(busy_m));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy_l), .din(din),
    .dout(dout_l), .dout_valid(vld_l), .last(last_l), .busy(busy_l));

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " vld"}, vld_m, 1'b0);
    chk({tag, " dout"}, dout_m, 1'b0);
    chk({tag, " dout_l"}, dout_l, 1'b0);
    chk({tag, " last"}, last_m, 1'b0);
    chk({tag, " busy"}, busy_m, 1'b0);
    chk({tag, " vld_l"}, vld_l, 1'b0);
  endtask

  task automatic check_bit(input vec_t v, input int i, input string tag);
    logic em, el;
    em = (i < W) ? v.seq_m[W-1-i] : v.par;
    el = (i < W) ? v.seq_l[W-1-i] : v.par;
    chk($sformatf("%s b%0d vld", tag, i), vld_m, 1'b1);
    chk($sformatf("%s b%0d dout_msb", tag, i), dout_m, em);
    chk($sformatf("%s b%0d dout_lsb", tag, i), dout_l, el);
    chk($sformatf("%s b%0d last", tag, i), last_m, i == FRAME - 1);
    chk($sformatf("%s b%0d ready", tag, i), rdy_m, i == FRAME - 1);
    chk($sformatf("%s b%0d busy", tag, i), busy_m, 1'b1);
  endtask

  task automatic play(input vec_t v, input string tag);
    @(negedge clk);
    chk_idle({tag, " idle"});
    chk({tag, " idle ready"}, rdy_m, 1'b1);
    din = v.word;
    din_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) din_valid = 1'b0;
      check_bit(v, i, tag);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{8'hB4, 8'hB4, 8'h2D, 1'b0};
    vecs[1] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    vecs[3] = '{8'h01, 8'h01, 8'h80, 1'b1};
    vecs[4] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[5] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};

    #1 rst = 1'b0;
    #1 chk_idle("reset async");
    chk("reset ready", rdy_m, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_idle("after reset");

    foreach (vecs[k]) play(vecs[k], $sformatf("vec%0d", k));
    @(negedge clk);
    chk_idle("post table");

    // back-to-back FF then 00 with din_valid held high throughout the first frame
    din = 8'hFF;
    din_valid = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("b2b %0d vld", i), vld_m, 1'b1);
      chk($sformatf("b2b %0d dout", i), dout_m, i < W);
      chk($sformatf("b2b %0d dout_l", i), dout_l, i < W);
      chk($sformatf("b2b %0d last", i), last_m, i == FRAME - 1 || i == 2 * FRAME - 1);
      if (i == FRAME - 1) din = 8'h00;
      if (i == FRAME) din_valid = 1'b0;
    end
    @(negedge clk);
    chk_idle("b2b end");

    // 55 pulsed mid-frame of AA must be ignored
    v = '{8'hAA, 8'hAA, 8'h55, 1'b0};
    din = 8'hAA;
    din_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      din_valid = (i == 3);
      if (i == 3) din = 8'h55;
      check_bit(v, i, "midpulse");
    end
    din_valid = 1'b0;
    @(negedge clk);
    chk_idle("midpulse end");

    // reset asserted between edges during bit 3 abandons the frame
    v = '{8'hB4, 8'hB4, 8'h2D, 1'b0};
    din = 8'hB4;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      check_bit(v, i, "prerst");
    end
    #2 rst = 1'b0;
    #1 chk_idle("rst mid");
    @(negedge clk);
    chk_idle("rst held");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("rst release %0d", i));
    end

    // acceptance on the first edge after release
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v = vecs[5];
    din = v.word;
    din_valid = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      din_valid = 1'b0;
      check_bit(v, i, "first_after_rst");
    end
    @(negedge clk);
    chk_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
